branch_recovery_unit: RTL and testbench

Consumes the resolved-branch stream from the branch execution unit and turns it into machine recovery actions. It registers branch/jump completions (link value, taken, mispredict) towards the ROB. On a mispredict it captures the offending ROB tag and target, pulses a squash to ROB/RS/rename and hands the corrected PC to fetch over a valid/ready handshake. It sits between the branch unit output and the fetch/ROB control paths. While recovering, an older mispredict always overrides a younger one.

---
 rtl/ooo_pkg.sv | 28 ++
 rtl/rob_age_cmp.sv | 23 ++
 rtl/branch_recovery_unit.sv | 133 +++++++++++++
 tb/tb_branch_recovery_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions.
//   br_rec_state_t : branch recovery FSM encoding (IDLE, FLUSH, REDIRECT)
//   rob_age()      : wrap-safe age of a ROB tag relative to the ROB head.
//                    The ROB and LSQ use the same helper.
package ooo_pkg;

  // Widest ROB tag that rob_age() supports.
  localparam int ROB_TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } br_rec_state_t;

  // age = (tag - head) mod 2^width. A smaller age means an older entry.
  // Tags are passed zero-extended to ROB_TAG_MAX_W bits.
  function automatic logic [ROB_TAG_MAX_W-1:0] rob_age(
    input logic [ROB_TAG_MAX_W-1:0] tag,
    input logic [ROB_TAG_MAX_W-1:0] head,
    input int                       width
  );
    logic [ROB_TAG_MAX_W-1:0] mask;
    mask = ROB_TAG_MAX_W'((32'd1 << width) - 32'd1);
    return (tag - head) & mask;
  endfunction

endpackage

// File: rtl/rob_age_cmp.sv
// Combinational wrap-safe age compare between two ROB tags.
//   a, b     : ROB tags to compare
//   head     : tag of the oldest ROB entry
//   is_older : 1 when a is strictly older than b (equal tags give 0)
module rob_age_cmp
  import ooo_pkg::*;
#(
  parameter int ROB_WIDTH = 4
) (
  input  logic [ROB_WIDTH-1:0] a,
  input  logic [ROB_WIDTH-1:0] b,
  input  logic [ROB_WIDTH-1:0] head,
  output logic                 is_older
);

  logic [ROB_TAG_MAX_W-1:0] age_a;
  logic [ROB_TAG_MAX_W-1:0] age_b;

  assign age_a    = rob_age(ROB_TAG_MAX_W'(a), ROB_TAG_MAX_W'(head), ROB_WIDTH);
  assign age_b    = rob_age(ROB_TAG_MAX_W'(b), ROB_TAG_MAX_W'(head), ROB_WIDTH);
  assign is_older = (age_a < age_b);

endmodule

// File: rtl/branch_recovery_unit.sv
// Branch recovery unit: turns resolved branches into ROB completions and, on
// a mispredict, into a one-cycle squash followed by a fetch redirect.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_br_*                : resolved-branch stream (one result per cycle, no
//                           backpressure)
//   i_rob_head            : oldest ROB tag, reference point for age compares
//   o_cmpl_*              : registered completion towards the ROB (1-cycle pulse)
//   o_flush*              : squash pulse; squash everything younger than the tag
//   o_redirect_*          : corrected PC to fetch, i_redirect_ready accepts it
//   o_busy                : recovery in progress, dispatch stalls
//   dbg_state             : current FSM state, observation only
//
// Redirect handshake: a transfer happens on a rising edge where
// o_redirect_valid and i_redirect_ready are both 1. Once valid is raised,
// o_redirect_pc and o_redirect_valid hold until that transfer; the only
// exception is an older mispredict, which drops valid for one FLUSH cycle and
// then presents the new PC. Ready may be high before valid.
module branch_recovery_unit
  import ooo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_br_valid,
  input  logic [ROB_WIDTH-1:0]  i_br_rob_tag,
  input  logic                  i_br_taken,
  input  logic [DATA_WIDTH-1:0] i_br_target_addr,
  input  logic                  i_br_mispredict,
  input  logic [DATA_WIDTH-1:0] i_br_result,
  input  logic [ROB_WIDTH-1:0]  i_rob_head,
  output logic                  o_cmpl_valid,
  output logic [ROB_WIDTH-1:0]  o_cmpl_rob_tag,
  output logic [DATA_WIDTH-1:0] o_cmpl_data,
  output logic                  o_cmpl_taken,
  output logic                  o_cmpl_mispredict,
  output logic                  o_flush,
  output logic [ROB_WIDTH-1:0]  o_flush_rob_tag,
  output logic                  o_redirect_valid,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  input  logic                  i_redirect_ready,
  output logic                  o_busy,
  output br_rec_state_t         dbg_state
);

  br_rec_state_t         state;
  br_rec_state_t         state_next;
  logic [ROB_WIDTH-1:0]  cap_tag;
  logic [DATA_WIDTH-1:0] cap_pc;

  logic br_older;
  logic stale;
  logic accept;
  logic capture;

  rob_age_cmp #(.ROB_WIDTH(ROB_WIDTH)) u_age_cmp (
    .a        (i_br_rob_tag),
    .b        (cap_tag),
    .head     (i_rob_head),
    .is_older (br_older)
  );

  // While recovering, anything not strictly older than the captured branch is
  // on the squashed path (an equal tag cannot legally occur and is dropped too).
  assign stale   = (state != IDLE) && !br_older;
  assign accept  = i_br_valid && !stale;
  // In IDLE every mispredict captures; while busy only older ones survive the
  // filter, so this also implements the older-mispredict override. A capture
  // wins over a same-cycle redirect handshake.
  assign capture = accept && i_br_mispredict;

  always_comb begin
    state_next       = state;
    o_flush          = 1'b0;
    o_flush_rob_tag  = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (capture) state_next = FLUSH;
      end
      FLUSH: begin
        o_flush         = 1'b1;
        o_flush_rob_tag = cap_tag;
        state_next      = capture ? FLUSH : REDIRECT;
      end
      REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = cap_pc;
        if (capture)               state_next = FLUSH;
        else if (i_redirect_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cap_tag <= '0;
      cap_pc  <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        cap_tag <= i_br_rob_tag;
        cap_pc  <= i_br_target_addr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cmpl_valid      <= 1'b0;
      o_cmpl_rob_tag    <= '0;
      o_cmpl_data       <= '0;
      o_cmpl_taken      <= 1'b0;
      o_cmpl_mispredict <= 1'b0;
    end else begin
      o_cmpl_valid <= accept;
      if (accept) begin
        o_cmpl_rob_tag    <= i_br_rob_tag;
        o_cmpl_data       <= i_br_result;
        o_cmpl_taken      <= i_br_taken;
        o_cmpl_mispredict <= i_br_mispredict;
      end
    end
  end

endmodule

// File: tb/tb_branch_recovery_unit.sv
// Directed bench for branch_recovery_unit: a vector table applied one record
// per cycle, then a hand-written reset-mid-recovery sequence.
module tb_branch_recovery_unit;
  import ooo_pkg::*;

  localparam int DW = 32;
  localparam int RW = 4;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          br_valid;
  logic [RW-1:0] br_rob_tag;
  logic          br_taken;
  logic [DW-1:0] br_target_addr;
  logic          br_mispredict;
  logic [DW-1:0] br_result;
  logic [RW-1:0] rob_head;
  logic          redirect_ready;
  logic          cmpl_valid;
  logic [RW-1:0] cmpl_rob_tag;
  logic [DW-1:0] cmpl_data;
  logic          cmpl_taken;
  logic          cmpl_mispredict;
  logic          flush;
  logic [RW-1:0] flush_rob_tag;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          busy;
  br_rec_state_t dbg_state;

  branch_recovery_unit #(.DATA_WIDTH(DW), .ROB_WIDTH(RW)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_br_valid        (br_valid),
    .i_br_rob_tag      (br_rob_tag),
    .i_br_taken        (br_taken),
    .i_br_target_addr  (br_target_addr),
    .i_br_mispredict   (br_mispredict),
    .i_br_result       (br_result),
    .i_rob_head        (rob_head),
    .o_cmpl_valid      (cmpl_valid),
    .o_cmpl_rob_tag    (cmpl_rob_tag),
    .o_cmpl_data       (cmpl_data),
    .o_cmpl_taken      (cmpl_taken),
    .o_cmpl_mispredict (cmpl_mispredict),
    .o_flush           (flush),
    .o_flush_rob_tag   (flush_rob_tag),
    .o_redirect_valid  (redirect_valid),
    .o_redirect_pc     (redirect_pc),
    .i_redirect_ready  (redirect_ready),
    .o_busy            (busy),
    .dbg_state         (dbg_state)
  );

  // redirect transfers seen by fetch
  int hs_count = 0;
  always @(posedge clk) begin
    if (rst_n && redirect_valid && redirect_ready) hs_count++;
  end

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          v;
    logic [RW-1:0] tag;
    logic          tk;
    logic [DW-1:0] tgt;
    logic          mp;
    logic [DW-1:0] res;
    logic [RW-1:0] head;
    logic          rdy;
    logic          e_cv;
    logic [RW-1:0] e_ctag;
    logic [DW-1:0] e_cdata;
    logic          e_ctk;
    logic          e_cmp;
    logic          e_fl;
    logic [RW-1:0] e_ftag;
    logic          e_rv;
    logic [DW-1:0] e_rpc;
    logic          e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic v, input int tag, input logic tk, input int tgt, input logic mp,
    input int res, input int head, input logic rdy,
    input logic e_cv, input int e_ctag, input int e_cdata, input logic e_ctk,
    input logic e_cmp, input logic e_fl, input int e_ftag, input logic e_rv,
    input int e_rpc, input logic e_busy
  );
    vec_t x;
    x.v = v;         x.tag = RW'(tag);       x.tk = tk;     x.tgt = DW'(tgt);
    x.mp = mp;       x.res = DW'(res);       x.head = RW'(head); x.rdy = rdy;
    x.e_cv = e_cv;   x.e_ctag = RW'(e_ctag); x.e_cdata = DW'(e_cdata);
    x.e_ctk = e_ctk; x.e_cmp = e_cmp;        x.e_fl = e_fl;
    x.e_ftag = RW'(e_ftag); x.e_rv = e_rv;   x.e_rpc = DW'(e_rpc); x.e_busy = e_busy;
    return x;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input int tag, input logic tk, input int tgt,
                       input logic mp, input int res, input int head, input logic rdy);
    br_valid       = v;
    br_rob_tag     = RW'(tag);
    br_taken       = tk;
    br_target_addr = DW'(tgt);
    br_mispredict  = mp;
    br_result      = DW'(res);
    rob_head       = RW'(head);
    redirect_ready = rdy;
  endtask

  task automatic drive_idle(input logic rdy);
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 0, rdy);
  endtask

  // Check of the full observable recovery state; cmpl payload only when valid.
  task automatic chk_outputs(input string p, input logic e_cv, input int e_ctag,
                             input int e_cdata, input logic e_ctk, input logic e_cmp,
                             input logic e_fl, input int e_ftag, input logic e_rv,
                             input int e_rpc, input logic e_busy);
    chk({p, " cmpl_valid"}, DW'(cmpl_valid), DW'(e_cv));
    if (e_cv) begin
      chk({p, " cmpl_tag"},  DW'(cmpl_rob_tag),    DW'(e_ctag));
      chk({p, " cmpl_data"}, cmpl_data,            DW'(e_cdata));
      chk({p, " cmpl_taken"}, DW'(cmpl_taken),     DW'(e_ctk));
      chk({p, " cmpl_mp"},   DW'(cmpl_mispredict), DW'(e_cmp));
    end
    chk({p, " flush"},          DW'(flush),          DW'(e_fl));
    chk({p, " flush_tag"},      DW'(flush_rob_tag),  DW'(e_ftag));
    chk({p, " redirect_valid"}, DW'(redirect_valid), DW'(e_rv));
    chk({p, " redirect_pc"},    redirect_pc,         DW'(e_rpc));
    chk({p, " busy"},           DW'(busy),           DW'(e_busy));
  endtask

  vec_t vecs[$];

  initial begin
    // Each row: inputs applied for one cycle, outputs expected right after
    // the edge that samples them.
    //           v  tag tk tgt    mp res    hd rdy | cv ctag cdata  ctk cmp fl ftag rv rpc    busy
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 0,  0,     0, 0,  0, 0,  0, 0,     0)); // 0 quiet
    vecs.push_back(mk(1, 3, 0, 'h108, 0, 'h104, 0, 0,  1, 3,  'h104, 0, 0,  0, 0,  0, 0,     0)); // 1 correct branch
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 0,  0,     0, 0,  0, 0,  0, 0,     0)); // 2 pulse ends
    vecs.push_back(mk(1, 5, 1, 'h200, 1, 'h108, 0, 1,  1, 5,  'h108, 1, 1,  1, 5,  0, 0,     1)); // 3 mispredict
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 1,  0, 0,  0,     0, 0,  0, 0,  1, 'h200, 1)); // 4 redirect
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 1,  0, 0,  0,     0, 0,  0, 0,  0, 0,     0)); // 5 back to IDLE
    vecs.push_back(mk(1, 5, 1, 'h200, 1, 'h108, 0, 0,  1, 5,  'h108, 1, 1,  1, 5,  0, 0,     1)); // 6 mispredict, ready low
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 0,  0,     0, 0,  0, 0,  1, 'h200, 1)); // 7
    vecs.push_back(mk(1, 7, 1, 'h700, 0, 'h11c, 0, 0,  0, 0,  0,     0, 0,  0, 0,  1, 'h200, 1)); // 8 younger: dropped
    vecs.push_back(mk(1, 5, 1, 'h220, 1, 'h108, 0, 0,  0, 0,  0,     0, 0,  0, 0,  1, 'h200, 1)); // 9 equal tag: dropped
    vecs.push_back(mk(1, 2, 0, 'h50,  0, 'h50,  0, 0,  1, 2,  'h50,  0, 0,  0, 0,  1, 'h200, 1)); // 10 older, correct
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 1,  0, 0,  0,     0, 0,  0, 0,  0, 0,     0)); // 11 handshake
    vecs.push_back(mk(1, 1, 1, 'h280, 1, 'h44,  14,0,  1, 1,  'h44,  1, 1,  1, 1,  0, 0,     1)); // 12 wrap: tag1 age3
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     14,0,  0, 0,  0,     0, 0,  0, 0,  1, 'h280, 1)); // 13
    vecs.push_back(mk(1, 15,1, 'h300, 1, 'h3c,  14,0,  1, 15, 'h3c,  1, 1,  1, 15, 0, 0,     1)); // 14 tag15 age1 overrides
    vecs.push_back(mk(1, 2, 1, 'h999, 1, 'h48,  14,0,  0, 0,  0,     0, 0,  0, 0,  1, 'h300, 1)); // 15 tag2 age4 dropped
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     14,1,  0, 0,  0,     0, 0,  0, 0,  0, 0,     0)); // 16 handshake
    vecs.push_back(mk(1, 8, 0, 'h400, 1, 'h220, 0, 0,  1, 8,  'h220, 0, 1,  1, 8,  0, 0,     1)); // 17 mispredict tag8
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 0,  0, 0,  0,     0, 0,  0, 0,  1, 'h400, 1)); // 18
    vecs.push_back(mk(1, 6, 1, 'h440, 1, 'h18,  0, 1,  1, 6,  'h18,  1, 1,  1, 6,  0, 0,     1)); // 19 handshake + recapture
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 1,  0, 0,  0,     0, 0,  0, 0,  1, 'h440, 1)); // 20
    vecs.push_back(mk(0, 0, 0, 0,     0, 0,     0, 1,  0, 0,  0,     0, 0,  0, 0,  0, 0,     0)); // 21 handshake

    // reset
    rst_n = 1'b0;
    drive_idle(1'b0);
    #12;
    chk_outputs("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("reset state", DW'(dbg_state), DW'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, int'(vecs[i].tag), vecs[i].tk, int'(vecs[i].tgt), vecs[i].mp,
            int'(vecs[i].res), int'(vecs[i].head), vecs[i].rdy);
      @(posedge clk);
      #1;
      chk_outputs($sformatf("v%0d", i), vecs[i].e_cv, int'(vecs[i].e_ctag),
                  int'(vecs[i].e_cdata), vecs[i].e_ctk, vecs[i].e_cmp, vecs[i].e_fl,
                  int'(vecs[i].e_ftag), vecs[i].e_rv, int'(vecs[i].e_rpc), vecs[i].e_busy);
    end
    chk("table handshakes", DW'(hs_count), DW'(5));

    // reset while in REDIRECT with fetch stalled
    @(negedge clk);
    drive(1'b1, 3, 1'b1, 'h500, 1'b1, 'h77, 0, 1'b0);
    @(posedge clk); #1;
    chk("rst_seq flush", DW'(flush), DW'(1));
    @(negedge clk);
    drive_idle(1'b0);
    @(posedge clk); #1;
    chk("rst_seq redirect_pc", redirect_pc, DW'('h500));
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs("mid_reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("mid_reset state", DW'(dbg_state), DW'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset no redirect", DW'(redirect_valid), DW'(0));
    chk("post_reset handshakes", DW'(hs_count), DW'(5));

    // next mispredict from IDLE, ready already high: 3 edges back to IDLE
    @(negedge clk);
    drive(1'b1, 4, 1'b0, 'h600, 1'b1, 'h14, 0, 1'b1);
    @(posedge clk); #1;
    chk_outputs("after_rst N+1", 1'b1, 4, 'h14, 1'b0, 1'b1, 1'b1, 4, 1'b0, 0, 1'b1);
    @(negedge clk);
    drive_idle(1'b1);
    @(posedge clk); #1;
    chk_outputs("after_rst N+2", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 'h600, 1'b1);
    @(posedge clk); #1;
    chk_outputs("after_rst N+3", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("final handshakes", DW'(hs_count), DW'(6));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard stop in case the sequence above never completes
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
